// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: register/latency widths,
// latency clamping and per-source index extraction.
package hazard_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int MAX_LAT  = 3;
    localparam int LAT_W    = $clog2(MAX_LAT + 1);
    localparam int MAX_SRC  = 4;

    typedef logic [LAT_W-1:0]  lat_t;
    typedef logic [REG_AW-1:0] reg_idx_t;

    // A zero latency still occupies the writeback slot for one cycle.
    function automatic lat_t clamp_lat(input lat_t lat);
        if (lat == lat_t'(0)) begin
            return lat_t'(1);
        end
        if (lat > lat_t'(MAX_LAT)) begin
            return lat_t'(MAX_LAT);
        end
        return lat;
    endfunction

    function automatic reg_idx_t src_idx(input logic [MAX_SRC*REG_AW-1:0] vec, input int i);
        return vec[i*REG_AW +: REG_AW];
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: a countdown of cycles until the pending write to this
// register lands in the register file.
module sb_entry
    import hazard_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  lat_t load_lat,
    output lat_t cnt,
    output logic busy,
    output logic is_one
);

    lat_t cnt_q;
    lat_t cnt_d;

    // A new load wins over the decrement of the write it replaces.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_lat;
        end else if (cnt_q != lat_t'(0)) begin
            cnt_d = cnt_q - lat_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt    = cnt_q;
    assign busy   = (cnt_q != lat_t'(0));
    assign is_one = (cnt_q == lat_t'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage RAW/WAW issue gate built on per-register countdown entries, with a
// saturating stall counter. Define HAZARD_SB_FORWARDING_EN to bypass cnt==1 producers.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      issue_valid,
    input  logic                      issue_we,
    input  logic [REG_AW-1:0]         issue_rd,
    input  logic [LAT_W-1:0]          issue_lat,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*REG_AW-1:0] src_reg,
    output logic                      stall,
    output logic [NUM_SRC-1:0]        fwd_sel,
    output logic                      issue_accept,
    output logic [NUM_REGS-1:0]       busy_vec,
    output logic [CNT_W-1:0]          stall_cnt
);

    lat_t                      eff_lat;
    lat_t                      cnt_arr [NUM_REGS];
    logic [NUM_REGS-1:0]       busy_w;
    logic [NUM_REGS-1:0]       one_w;
    logic [NUM_REGS-1:1]       load_vec;
    logic [MAX_SRC*REG_AW-1:0] src_ext;
    logic [NUM_SRC-1:0]        raw_hz;
    logic [NUM_SRC-1:0]        fwd_hit;
    logic                      waw_hz;
    logic [CNT_W-1:0]          stall_cnt_q;
    logic [CNT_W-1:0]          stall_cnt_d;

    assign eff_lat = clamp_lat(issue_lat);
    assign src_ext = (MAX_SRC*REG_AW)'(src_reg);

    // Register 0 is hardwired zero, so it has no entry and is never pending.
    assign cnt_arr[0] = '0;
    assign busy_w[0]  = 1'b0;
    assign one_w[0]   = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        assign load_vec[r] = issue_accept & issue_we & (issue_rd == REG_AW'(r));

        sb_entry u_entry (
            .clk      (clk),
            .reset    (reset),
            .load     (load_vec[r]),
            .load_lat (eff_lat),
            .cnt      (cnt_arr[r]),
            .busy     (busy_w[r]),
            .is_one   (one_w[r])
        );
    end

    always_comb begin
        reg_idx_t idx;
        idx     = '0;
        raw_hz  = '0;
        fwd_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = src_idx(src_ext, i);
            if (src_valid[i]) begin
`ifdef HAZARD_SB_FORWARDING_EN
                // A producer at cnt==1 is on the bypass network this cycle.
                if (one_w[idx]) begin
                    fwd_hit[i] = 1'b1;
                end else begin
                    raw_hz[i] = busy_w[idx];
                end
`else
                raw_hz[i] = busy_w[idx] | one_w[idx];
`endif
            end
        end
    end

    // Keeps writebacks in order: a new write may not finish before an older one to rd.
    assign waw_hz = issue_valid & issue_we & (issue_rd != '0) & (cnt_arr[issue_rd] > eff_lat);

    assign stall        = reset | (issue_valid & ((|raw_hz) | waw_hz));
    assign issue_accept = issue_valid & ~stall & ~flush & ~reset;
    assign fwd_sel      = reset ? '0 : fwd_hit;
    assign busy_vec     = busy_w;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_valid && stall && !reset && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: reset, RAW, r0, WAW, flush, latency clamp
// and stall counter saturation, each with hand-derived expected values.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    localparam int NUM_SRC = 2;
    localparam int CNT_W   = 16;

`ifdef HAZARD_SB_FORWARDING_EN
    localparam int RAW_STALLS = 2;
    localparam int FWD_EXP    = 1;
    localparam int SAT_PERIOD = 3;
    localparam int SAT_LOOPS  = 32768;
`else
    localparam int RAW_STALLS = 3;
    localparam int FWD_EXP    = 0;
    localparam int SAT_PERIOD = 4;
    localparam int SAT_LOOPS  = 21846;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic                      issue_valid;
    logic                      issue_we;
    logic [REG_AW-1:0]         issue_rd;
    logic [LAT_W-1:0]          issue_lat;
    logic                      flush;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*REG_AW-1:0] src_reg;
    logic                      stall;
    logic [NUM_SRC-1:0]        fwd_sel;
    logic                      issue_accept;
    logic [NUM_REGS-1:0]       busy_vec;
    logic [CNT_W-1:0]          stall_cnt;

    int compared   = 0;
    int mismatched = 0;

    hazard_scoreboard #(
        .NUM_SRC (NUM_SRC),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_rd     (issue_rd),
        .issue_lat    (issue_lat),
        .flush        (flush),
        .src_valid    (src_valid),
        .src_reg      (src_reg),
        .stall        (stall),
        .fwd_sel      (fwd_sel),
        .issue_accept (issue_accept),
        .busy_vec     (busy_vec),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic we, input logic [4:0] rd,
                                 input logic [1:0] lat, input logic fl, input logic [1:0] sv,
                                 input logic [4:0] s0, input logic [4:0] s1);
        issue_valid = v;
        issue_we    = we;
        issue_rd    = rd;
        issue_lat   = lat;
        flush       = fl;
        src_valid   = sv;
        src_reg     = {s1, s0};
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int patternErr;
        patternErr = 0;

        // Reset held with a valid instruction presented.
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 5'd5, 2'd3, 1'b0, 2'b01, 5'd5, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("rst_stall", 32'(stall), 32'd1);
            checkOutput("rst_accept", 32'(issue_accept), 32'd0);
            checkOutput("rst_busy", busy_vec, 32'd0);
            checkOutput("rst_cnt", 32'(stall_cnt), 32'd0);
            checkOutput("rst_fwd", 32'(fwd_sel), 32'd0);
            nextCycle();
        end
        reset = 1'b0;

        // RAW: rd=5 lat=3, then a reader of r5.
        applyStimulus(1'b1, 1'b1, 5'd5, 2'd3, 1'b0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("raw_wr_accept", 32'(issue_accept), 32'd1);
        checkOutput("raw_wr_stall", 32'(stall), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd3, 1'b0, 2'b01, 5'd5, 5'd0);
        for (int k = 0; k <= RAW_STALLS; k++) begin
            @(negedge clk);
            if (k == 0) checkOutput("raw_busy5", busy_vec, 32'h0000_0020);
            checkOutput("raw_stall", 32'(stall), (k < RAW_STALLS) ? 32'd1 : 32'd0);
            checkOutput("raw_accept", 32'(issue_accept), (k == RAW_STALLS) ? 32'd1 : 32'd0);
            if (k == RAW_STALLS) checkOutput("raw_fwd", 32'(fwd_sel[0]), 32'(FWD_EXP));
            nextCycle();
        end

        // r0 as destination and source never hazards.
        applyStimulus(1'b1, 1'b1, 5'd0, 2'd3, 1'b0, 2'b01, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("r0_stall", 32'(stall), 32'd0);
        checkOutput("r0_accept", 32'(issue_accept), 32'd1);
        checkOutput("raw_stall_cnt", 32'(stall_cnt), 32'(RAW_STALLS));
        nextCycle();
        applyStimulus(1'b1, 1'b0, 5'd0, 2'd1, 1'b0, 2'b11, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("r0_busy", busy_vec, 32'd0);
        checkOutput("r0_src_stall", 32'(stall), 32'd0);
        nextCycle();

        // WAW: rd=7 lat=3 then rd=7 lat=1 waits until cnt[7]<=1.
        applyStimulus(1'b1, 1'b1, 5'd7, 2'd3, 1'b0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("waw_first_accept", 32'(issue_accept), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd7, 2'd1, 1'b0, 2'b00, 5'd0, 5'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("waw_stall", 32'(stall), (k < 2) ? 32'd1 : 32'd0);
            checkOutput("waw_accept", 32'(issue_accept), (k == 2) ? 32'd1 : 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("waw_busy7_set", busy_vec, 32'h0000_0080);
        nextCycle();
        @(negedge clk);
        checkOutput("waw_busy7_clr", busy_vec, 32'd0);
        checkOutput("waw_stall_cnt", 32'(stall_cnt), 32'(RAW_STALLS + 2));

        // Flush squashes rd=9 while older rd=4 keeps counting.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd4, 2'd2, 1'b0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("fl_old_accept", 32'(issue_accept), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd9, 2'd2, 1'b1, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("fl_accept", 32'(issue_accept), 32'd0);
        checkOutput("fl_stall", 32'(stall), 32'd0);
        checkOutput("fl_busy_a", busy_vec, 32'h0000_0010);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("fl_busy_b", busy_vec, 32'h0000_0010);
        nextCycle();
        @(negedge clk);
        checkOutput("fl_busy_c", busy_vec, 32'd0);

        // Latency 0 behaves as latency 1.
        nextCycle();
        applyStimulus(1'b1, 1'b1, 5'd3, 2'd0, 1'b0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lat0_accept", 32'(issue_accept), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        checkOutput("lat0_busy_set", busy_vec, 32'h0000_0008);
        nextCycle();
        @(negedge clk);
        checkOutput("lat0_busy_clr", busy_vec, 32'd0);
        nextCycle();

        // Self-dependent writer to r10: accept once per period, stall otherwise.
        applyStimulus(1'b1, 1'b1, 5'd10, 2'd3, 1'b0, 2'b01, 5'd10, 5'd0);
        for (int p = 0; p < SAT_LOOPS; p++) begin
            for (int ph = 0; ph < SAT_PERIOD; ph++) begin
                @(negedge clk);
                if (stall !== (ph != 0)) patternErr++;
                nextCycle();
            end
        end
        @(negedge clk);
        checkOutput("sat_pattern_errs", 32'(patternErr), 32'd0);
        checkOutput("sat_value", 32'(stall_cnt), 32'h0000_FFFF);
        nextCycle();
        @(negedge clk);
        checkOutput("sat_stalling", 32'(stall), 32'd1);
        nextCycle();
        @(negedge clk);
        checkOutput("sat_hold", 32'(stall_cnt), 32'h0000_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
